keyboard_encoder: RTL and testbench

KEYBOARD_ENCODER -- requirements
Module: keyboard_encoder

---
 rtl/enigma_pkg.sv | 23 ++
 rtl/key_sync.sv | 24 ++
 rtl/keyboard_encoder.sv | 121 ++++++++++++
 tb/tb_keyboard_encoder.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/enigma_pkg.sv
// Shared Enigma definitions: letter encoding width and keyboard encoder types.
package enigma_pkg;

  localparam int unsigned LETTER_W    = 6;
  localparam int unsigned NUM_LETTERS = 26;

  typedef logic [LETTER_W-1:0]    letter_t;
  typedef logic [NUM_LETTERS-1:0] key_vec_t;

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    DEBOUNCE     = 2'd1,
    EMIT         = 2'd2,
    WAIT_RELEASE = 2'd3
  } kb_state_t;

  // Key press captured in IDLE and held through DEBOUNCE and EMIT
  typedef struct packed {
    key_vec_t vec;
    letter_t  idx;
  } kb_capture_t;

endpackage

// File: rtl/key_sync.sv
// Two-flop synchronizer for a vector of slow, asynchronous level inputs.
module key_sync #(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  // First stage may go metastable; second stage feeds the core logic
  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/keyboard_encoder.sv
// Debounces 26 raw key lines and emits one letter code per accepted press.
module keyboard_encoder
  import enigma_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_LETTERS-1:0] key_in,
  input  logic                   data_ready,
  output logic [LETTER_W-1:0]    data_out,
  output logic                   data_valid,
  output logic                   busy
);

  localparam int unsigned     CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_DONE = CNT_W'(DEBOUNCE_CYCLES);

  key_vec_t         key_s;
  kb_state_t        state, state_n;
  kb_capture_t      cap, cap_n;
  logic [CNT_W-1:0] cnt, cnt_n, cnt_inc_c;
  logic             one_hot_c;
  letter_t          key_idx_c;
  logic             valid_n, busy_n;
  letter_t          out_n;

  key_sync #(
    .WIDTH(NUM_LETTERS)
  ) u_key_sync (
    .clk(clk),
    .rst(rst),
    .d  (key_in),
    .q  (key_s)
  );

  // Exactly-one-key detection and binary index of the set bit
  always_comb begin
    one_hot_c = (key_s != '0) && ((key_s & (key_s - key_vec_t'(1))) == '0);
    key_idx_c = '0;
    for (int unsigned i = 0; i < NUM_LETTERS; i++) begin
      if (key_s[i]) key_idx_c = LETTER_W'(i);
    end
  end

  // Saturating increment so the counter can never wrap back to zero
  assign cnt_inc_c = (cnt == CNT_DONE) ? cnt : cnt + CNT_W'(1);

  // Next-state, counter, capture and output decisions
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    cap_n   = cap;
    unique case (state)
      IDLE: begin
        if (one_hot_c) begin
          cap_n.vec = key_s;
          cap_n.idx = key_idx_c;
          cnt_n     = '0;
          state_n   = DEBOUNCE;
        end
      end
      DEBOUNCE: begin
        if (key_s != cap.vec) begin
          cnt_n   = '0;
          state_n = IDLE;
        end else if (cnt_inc_c == CNT_DONE) begin
          cnt_n   = '0;
          state_n = EMIT;
        end else begin
          cnt_n = cnt_inc_c;
        end
      end
      EMIT: begin
        // Key activity is ignored here: the pending keystroke stands
        if (data_valid && data_ready) begin
          cnt_n   = '0;
          state_n = WAIT_RELEASE;
        end
      end
      WAIT_RELEASE: begin
        if (key_s != '0) begin
          cnt_n = '0;
        end else if (cnt_inc_c == CNT_DONE) begin
          cnt_n   = '0;
          state_n = IDLE;
        end else begin
          cnt_n = cnt_inc_c;
        end
      end
      default: begin
        cnt_n   = '0;
        state_n = WAIT_RELEASE;
      end
    endcase

    valid_n = (state_n == EMIT);
    out_n   = valid_n ? cap_n.idx : '0;
    busy_n  = (state_n != IDLE);
  end

  // State register; reset parks in WAIT_RELEASE so held keys are not emitted
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= WAIT_RELEASE;
      cnt        <= '0;
      cap        <= '0;
      data_valid <= 1'b0;
      data_out   <= '0;
      busy       <= 1'b1;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      cap        <= cap_n;
      data_valid <= valid_n;
      data_out   <= out_n;
      busy       <= busy_n;
    end
  end

endmodule

// File: tb/tb_keyboard_encoder.sv
// Bench for keyboard_encoder with DEBOUNCE_CYCLES = 4.
module tb_keyboard_encoder;

  localparam int unsigned N = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [25:0] key_in;
  logic        data_ready;
  logic [5:0]  data_out;
  logic        data_valid;
  logic        busy;

  int checks    = 0;
  int errors    = 0;
  int emissions = 0;
  bit chk_en    = 1'b0;

  // Behavioural model state
  logic [25:0] m_s1  = '0;
  logic [25:0] m_s2  = '0;
  logic        m_rdy = 1'b0;
  logic        m_valid = 1'b0;
  logic [5:0]  m_out   = '0;
  logic        m_busy  = 1'b1;

  keyboard_encoder #(.DEBOUNCE_CYCLES(N)) dut (
    .clk       (clk),
    .rst       (rst),
    .key_in    (key_in),
    .data_ready(data_ready),
    .data_out  (data_out),
    .data_valid(data_valid),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // One clock edge of the model: returns what the core sees this edge
  task automatic step(output logic [25:0] ks, output logic r);
    @(posedge clk);
    ks    = m_s2;
    r     = rst;
    m_rdy = data_ready;
    if (rst) begin
      m_s2 = '0;
      m_s1 = '0;
    end else begin
      m_s2 = m_s1;
      m_s1 = key_in;
    end
  endtask

  // Press lifecycle written as a sequential story per keystroke
  initial begin : model
    logic [25:0] ks, v;
    logic        r;
    int unsigned zeros;
    bit          good, skip_release;
    skip_release = 1'b0;
    forever begin
      if (!skip_release) begin
        m_valid = 1'b0;
        m_out   = '0;
        m_busy  = 1'b1;
        zeros   = 0;
        while (zeros < N) begin
          step(ks, r);
          zeros = (r || ks != '0) ? 0 : zeros + 1;
        end
      end
      skip_release = 1'b0;
      m_busy = 1'b0;
      do step(ks, r); while (!r && $countones(ks) != 1);
      if (r) continue;
      m_busy = 1'b1;
      v      = ks;
      good   = 1'b1;
      for (int k = 0; k < int'(N); k++) begin
        step(ks, r);
        if (r || ks != v) begin
          good = 1'b0;
          break;
        end
      end
      if (r) continue;
      if (!good) begin
        skip_release = 1'b1;
        continue;
      end
      m_valid = 1'b1;
      m_out   = 6'($clog2(v));
      do step(ks, r); while (!r && !m_rdy);
    end
  end

  // Cycle-by-cycle comparison against the model
  always @(posedge clk) begin
    #1;
    if (chk_en) begin
      chk("cyc_valid", 32'(data_valid), 32'(m_valid));
      chk("cyc_data_out", 32'(data_out), 32'(m_out));
      chk("cyc_busy", 32'(busy), 32'(m_busy));
    end
  end

  // Accepted keystrokes as seen by the consumer
  always @(posedge clk) begin
    if (!rst && data_valid === 1'b1 && data_ready === 1'b1) emissions++;
  end

  initial begin
    rst        = 1'b1;
    key_in     = '0;
    data_ready = 1'b0;
    @(negedge clk);
    chk_en = 1'b1;
    @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd1);
    chk("rst_valid", 32'(data_valid), 32'd0);
    chk("rst_data_out", 32'(data_out), 32'd0);
    rst = 1'b0;

    // Idle after reset: busy drops on the 4th zero cycle
    cyc(3);
    chk("idle_busy_3", 32'(busy), 32'd1);
    cyc(1);
    chk("idle_busy_4", 32'(busy), 32'd0);
    cyc(2);

    // H pressed with consumer ready: single emission on edge 7
    data_ready = 1'b1;
    key_in     = 26'(1) << 7;
    cyc(6);
    chk("h_valid_e6", 32'(data_valid), 32'd0);
    cyc(1);
    chk("h_valid_e7", 32'(data_valid), 32'd1);
    chk("h_data_out_e7", 32'(data_out), 32'd7);
    chk("model_h_valid", 32'(m_valid), 32'd1);
    chk("model_h_out", 32'(m_out), 32'd7);
    cyc(1);
    chk("h_valid_e8", 32'(data_valid), 32'd0);
    cyc(42);
    chk("h_no_repeat", 32'(emissions), 32'd1);
    key_in = '0;
    cyc(8);
    chk("h_idle", 32'(busy), 32'd0);

    // A pressed with consumer stalled; release during EMIT
    data_ready = 1'b0;
    key_in     = 26'(1);
    cyc(9);
    key_in = '0;
    cyc(1);
    chk("a_valid_held", 32'(data_valid), 32'd1);
    chk("a_data_out_held", 32'(data_out), 32'd0);
    chk("a_not_accepted", 32'(emissions), 32'd1);
    data_ready = 1'b1;
    cyc(1);
    chk("a_valid_drop", 32'(data_valid), 32'd0);
    chk("a_accepted", 32'(emissions), 32'd2);
    cyc(3);
    chk("a_busy_3", 32'(busy), 32'd1);
    cyc(1);
    chk("a_busy_4", 32'(busy), 32'd0);

    // Short glitch on Z, then two keys together
    key_in = 26'(1) << 25;
    cyc(2);
    key_in = '0;
    cyc(8);
    chk("glitch_none", 32'(emissions), 32'd2);
    key_in = (26'(1) << 3) | (26'(1) << 4);
    cyc(12);
    key_in = '0;
    cyc(8);
    chk("dual_none", 32'(emissions), 32'd2);
    chk("dual_idle", 32'(busy), 32'd0);

    // T held across a reset pulse is discarded, a fresh press is not
    key_in = 26'(1) << 19;
    cyc(3);
    rst = 1'b1;
    cyc(2);
    chk("t_rst_busy", 32'(busy), 32'd1);
    rst = 1'b0;
    cyc(20);
    chk("t_held_none", 32'(emissions), 32'd2);
    key_in = '0;
    cyc(8);
    chk("t_idle", 32'(busy), 32'd0);
    key_in = 26'(1) << 19;
    cyc(7);
    chk("t_valid", 32'(data_valid), 32'd1);
    chk("t_data_out", 32'(data_out), 32'd19);
    cyc(1);
    chk("t_accepted", 32'(emissions), 32'd3);
    key_in = '0;
    cyc(8);

    // Reset while M is pending in EMIT
    data_ready = 1'b0;
    key_in     = 26'(1) << 12;
    cyc(8);
    chk("m_valid", 32'(data_valid), 32'd1);
    chk("m_data_out", 32'(data_out), 32'd12);
    rst = 1'b1;
    cyc(1);
    chk("m_rst_valid", 32'(data_valid), 32'd0);
    chk("m_rst_data_out", 32'(data_out), 32'd0);
    rst        = 1'b0;
    data_ready = 1'b1;
    cyc(20);
    chk("m_discarded", 32'(emissions), 32'd3);
    key_in = '0;
    cyc(8);
    chk("m_idle", 32'(busy), 32'd0);
    chk("final_emissions", 32'(emissions), 32'd3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
